// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: state and phase encodings,
// lamp codes and default interval codes.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG_BASE = 3'd0,
        MG_EXT  = 3'd1,
        MY      = 3'd2,
        SG      = 3'd3,
        SG_EXT  = 3'd4,
        SY      = 3'd5,
        WALK    = 3'd6
    } state_t;

    typedef enum logic {
        LOAD = 1'b0,
        WAIT = 1'b1
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] T_BASE_DEF = 4'd6;
    localparam logic [3:0] T_EXT_DEF  = 4'd3;
    localparam logic [3:0] T_YEL_DEF  = 4'd2;

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Handshake between the light sequencer (master) and the interval timer (slave):
// a one-cycle load pulse with an interval code, and the expiry flag back.
interface traffic_light_fsm_if;

    logic       start_timer;
    logic [3:0] value;
    logic       expired;

    modport master (output start_timer, output value, input expired);
    modport slave  (input start_timer, input value, output expired);

endinterface

// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer driving the interval timer; optional pedestrian walk
// phase is enabled by defining TRAFFIC_WALK_EN.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_BASE = T_BASE_DEF,
    parameter logic [3:0] T_EXT  = T_EXT_DEF,
    parameter logic [3:0] T_YEL  = T_YEL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_fsm_if.master  tmr,
    input  logic                 sensor,
    input  logic                 walk_request,
    output logic [2:0]           light_main,
    output logic [2:0]           light_side,
    output logic                 walk
);

    state_t state, state_nx;
    phase_t phase, phase_nx;

`ifdef TRAFFIC_WALK_EN
    logic walk_pending, walk_pending_nx;
`else
    logic unused_walk_request;
    assign unused_walk_request = walk_request;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MG_BASE;
            phase <= LOAD;
`ifdef TRAFFIC_WALK_EN
            walk_pending <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            phase <= phase_nx;
`ifdef TRAFFIC_WALK_EN
            walk_pending <= walk_pending_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
`ifdef TRAFFIC_WALK_EN
        walk_pending_nx = walk_pending | walk_request;
`endif
        // Expiry is only honoured from WAIT, so a stale high level during LOAD is harmless
        if (phase == LOAD) begin
            phase_nx = WAIT;
        end else if (tmr.expired) begin
            phase_nx = LOAD;
            case (state)
                MG_BASE: state_nx = sensor ? MY : MG_EXT;
                MG_EXT:  state_nx = MY;
`ifdef TRAFFIC_WALK_EN
                MY:      state_nx = (walk_pending || walk_request) ? WALK : SG;
`else
                MY:      state_nx = SG;
`endif
                SG:      state_nx = sensor ? SG_EXT : SY;
                SG_EXT:  state_nx = SY;
                SY:      state_nx = MG_BASE;
                WALK:    state_nx = SG;
                default: state_nx = MG_BASE;
            endcase
`ifdef TRAFFIC_WALK_EN
            if (state_nx == WALK) walk_pending_nx = 1'b0;
`endif
        end
    end

    always_comb begin
        light_main      = GRN;
        light_side      = RED;
        walk            = 1'b0;
        tmr.value       = T_BASE;
        // Gated by reset so no load pulse escapes while the controller is held
        tmr.start_timer = rst_n && (phase == LOAD);
        case (state)
            MG_BASE: begin light_main = GRN; light_side = RED; tmr.value = T_BASE; end
            MG_EXT:  begin light_main = GRN; light_side = RED; tmr.value = T_EXT;  end
            MY:      begin light_main = YEL; light_side = RED; tmr.value = T_YEL;  end
            SG:      begin light_main = RED; light_side = GRN; tmr.value = T_BASE; end
            SG_EXT:  begin light_main = RED; light_side = GRN; tmr.value = T_EXT;  end
            SY:      begin light_main = RED; light_side = YEL; tmr.value = T_YEL;  end
            WALK: begin
                light_main = RED;
                light_side = RED;
                tmr.value  = T_EXT;
`ifdef TRAFFIC_WALK_EN
                walk       = 1'b1;
`endif
            end
            default: begin light_main = GRN; light_side = RED; tmr.value = T_BASE; end
        endcase
    end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Initiator side of the interval-timer interface.
- Sequences main- and side-road lights, loads an interval code into the timer with a one-cycle start pulse, and advances when the timer reports expiry.
- Side-road car sensor extends or skips green intervals; an optional pedestrian walk phase is available.
- Sits above the timer and 1 Hz divider in the traffic-light top level.

Parameters:
- T_BASE, 4'd6, base green interval code sent on value.
- T_EXT, 4'd3, extension interval code, also used for the walk phase.
- T_YEL, 4'd2, yellow interval code.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  reset; one clock, reset is asynchronous and active-low.
- expired  input  1  from timer; high when the loaded interval has elapsed.
- sensor  input  1  side-road car present, synchronous to clk.
- walk_request  input  1  pedestrian button, synchronous, pulse or level.
- start_timer  output  1  one-cycle pulse, loads value into the timer.
- value  output  4  interval code; valid in the start_timer cycle, held until the next load.
- light_main  output  3  {R,Y,G} one-hot for the main road.
- light_side  output  3  {R,Y,G} one-hot for the side road.
- walk  output  1  pedestrian walk lamp.

Behaviour:
- States: MG_BASE, MG_EXT, MY, SG, SG_EXT, SY, plus WALK (feature only).
- Each state has a LOAD phase then a WAIT phase, tracked by a 1-bit phase register.
- LOAD phase (exactly 1 cycle on state entry):
  - start_timer=1 and value=interval of the state.
  - expired is ignored in this cycle.
- WAIT phase:
  - start_timer=0.
  - The transition is taken on the first rising edge where expired=1.
  - The next state enters LOAD.
- Timer contract: expired is low no later than the cycle after start_timer.
- Intervals per state:
  - MG_BASE, SG: T_BASE.
  - MG_EXT, SG_EXT: T_EXT.
  - MY, SY: T_YEL.
  - WALK: T_EXT.
- Transitions on expiry:
  - MG_BASE → MY if sensor=1, else MG_EXT.
  - MG_EXT → MY.
  - MY → SG (feature off), or WALK/SG (feature on, see Optional Feature).
  - SG → SG_EXT if sensor=1, else SY.
  - SG_EXT → SY.
  - SY → MG_BASE.
- sensor is sampled only on the expiry edge.
- Lights are Moore, decoded from state:
  - MG_*: main=G(001), side=R(100).
  - MY: main=Y(010), side=R.
  - SG*: main=R, side=G.
  - SY: main=R, side=Y.
  - WALK: both R, walk=1.
  - walk=0 in all other states.
- Reset asserted (async):
  - state=MG_BASE, phase=LOAD.
  - start_timer=0, value=T_BASE.
  - light_main=001, light_side=100, walk=0, walk latch cleared.
  - The first cycle after release is a LOAD: start_timer=1, value=T_BASE.
- Reset mid-interval: abandons the interval and the timer is reloaded as above. Never emit more than one start_timer per state entry.
- expired held high across the LOAD cycle: ignored; evaluation occurs from WAIT only.
- Lights never show both roads non-red simultaneously. This is a verification assertion.

Optional Feature:
- Macro: TRAFFIC_WALK_EN.
- Defined:
  - A walk_pending flop sets on any cycle with walk_request=1 and clears on entry to WALK.
  - MY expiry goes to WALK if walk_pending=1 (or walk_request=1 that edge), else SG.
  - WALK expiry → SG.
  - walk_request during WALK re-sets pending for the next cycle round.
- Undefined:
  - No WALK state, no latch; walk is tied 0.
  - walk_request is ignored (port kept).

Decomposition:
- Shared package traffic_pkg:
  - state encoding constants.
  - light codes RED=3'b100, YEL=3'b010, GRN=3'b001.
  - default interval codes matching T_BASE/T_EXT/T_YEL.
- Single module; no sub-module warranted.
- The timer and divider stay separate and are instanced alongside at top level.

Test Plan:
- Reset low 4 cycles then release, timer model returns expired 6 cycles after start → start_timer pulse first cycle with value=6, lights main=001 side=100.
- sensor=0 throughout → sequence MG_BASE(6), MG_EXT(3), MY(2), SG(6), SY(2), MG_BASE.
  - Check value on each start pulse and exactly one pulse per state.
- sensor=1 throughout → MG_BASE(6), MY(2), SG(6), SG_EXT(3), SY(2).
  - Side lights 001 during SG and SG_EXT, 010 during SY.
- Reset asserted mid-SG (cycle 3 of WAIT) → lights immediately 001/100, walk=0; after release, start_timer with value=6.
- expired forced high during a LOAD cycle → no transition; transition occurs only on a later expired edge.
- TRAFFIC_WALK_EN: pulse walk_request one cycle during MG_BASE → after MY, WALK with value=3, both lights 100, walk=1, then SG; the following round skips WALK.
